spi_slave: RTL and testbench

//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the far end of the SPI link driven by
//  the team's SPI master and clock divider. Oversamples sclk/cs_n/mosi on the system clock,

---
 rtl/spi_slave_if.sv | 28 ++
 rtl/spi_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI pad signals plus the local TX/RX handshake of the SPI responder, grouped for
// connection between the responder (slave modport) and whatever drives it (master modport).
interface spi_slave_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              tx_underrun;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, frame_err, tx_underrun
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, frame_err, tx_underrun
  );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversamples the SPI pins on clk, deserialises MOSI into rx_data and
// shifts a one-entry TX holding register out on MISO, with back-to-back frames under one cs_n.
module spi_slave #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] TX_IDLE = 8'hFF
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_slave_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sclk_s1_q, sclk_s2_q, sclk_d_q;
  logic              cs_s1_q, cs_s2_q, cs_d_q;
  logic              mosi_s1_q, mosi_s2_q;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              tx_ready_q;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              reload_q, reload_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              load_s;

  logic              sclk_rise_s, sclk_fall_s, cs_fall_s, tx_wr_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [DATA_W-1:0] load_val_s;

  assign sclk_rise_s = sclk_s2_q & ~sclk_d_q;
  assign sclk_fall_s = ~sclk_s2_q & sclk_d_q;
  assign cs_fall_s   = ~cs_s2_q & cs_d_q;
  assign tx_wr_s     = bus.tx_valid & ~buf_full_q;
  assign cnt_inc_s   = bit_cnt_q + CNT_ONE;
  assign load_val_s  = buf_full_q ? buf_q : TX_IDLE;

  // Two-flop synchronisers plus one delayed copy for edge detection on the SPI pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_d_q  <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_d_q    <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= bus.sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_d_q  <= sclk_s2_q;
      cs_s1_q   <= bus.cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_d_q    <= cs_s2_q;
      mosi_s1_q <= bus.mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // Frame sequencing and shift datapath next-state
  always_comb begin
    state_d       = state_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    reload_d      = reload_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    tx_underrun_d = 1'b0;
    load_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        reload_d = 1'b0;
        if (cs_fall_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_s    = 1'b1;
        bit_cnt_d = CNT_ZERO;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cs_s2_q) begin
          state_d = ST_IDLE;
          // Deselect is only an error once a frame has started and not yet completed
          if ((bit_cnt_q != CNT_ZERO) && (bit_cnt_q != CNT_FULL)) begin
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = 1'b0;
          end
        end else if (sclk_rise_s && (bit_cnt_q < CNT_FULL)) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s2_q};
          bit_cnt_d  = cnt_inc_s;
          if (cnt_inc_s == CNT_FULL) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (sclk_fall_s) begin
          if (reload_q) begin
            load_s    = 1'b1;
            reload_d  = 1'b0;
            bit_cnt_d = CNT_ZERO;
          end else if (bit_cnt_q != CNT_ZERO) begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_W-2];
          end else begin
            tx_shift_d = tx_shift_q;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        reload_d   = 1'b1;
        if (cs_s2_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (load_s) begin
      tx_shift_d    = load_val_s;
      miso_d        = load_val_s[DATA_W-1];
      tx_underrun_d = ~buf_full_q;
    end else begin
      tx_underrun_d = 1'b0;
    end
    if (state_d == ST_IDLE) begin
      miso_d = 1'b0;
    end else begin
      miso_d = miso_d;
    end
  end

  // TX holding register: a load consumes the old content, a write only lands when empty
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (tx_wr_s) begin
      buf_d      = bus.tx_data;
      buf_full_d = 1'b1;
    end else if (load_s) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      buf_q         <= {DATA_W{1'b0}};
      buf_full_q    <= 1'b0;
      tx_ready_q    <= 1'b1;
      tx_shift_q    <= {DATA_W{1'b0}};
      rx_shift_q    <= {DATA_W{1'b0}};
      bit_cnt_q     <= CNT_ZERO;
      reload_q      <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_data_q     <= {DATA_W{1'b0}};
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      tx_ready_q    <= ~buf_full_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      reload_q      <= reload_d;
      miso_q        <= miso_d;
      miso_oe_q     <= (state_d != ST_IDLE);
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master, frame-level reference model of the TX buffer
// and expected RX bytes, and a per-cycle monitor comparing DUT outputs to that model.
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  spi_slave_if #(.DATA_W(8)) bus ();
  spi_slave #(.DATA_W(8), .TX_IDLE(8'hFF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] exp_rx[$];
  logic       model_full = 1'b0;
  logic [7:0] model_buf = 8'h00;
  logic [7:0] cur_tx = 8'hFF;
  int         n_rx = 0;
  int         exp_ferr = 0;
  int         exp_und = 0;

  // monitor state
  int         act_rxv = 0;
  int         act_ferr = 0;
  int         act_und = 0;
  logic [7:0] last_rx = 8'h00;
  logic       prev_rxv = 1'b0;
  logic       prev_cs = 1'b1;
  int         cs_stable = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A frame load takes the buffered byte, else the idle byte with an underrun
  function automatic logic [7:0] model_load();
    if (model_full) begin
      model_full = 1'b0;
      return model_buf;
    end
    exp_und++;
    return 8'hFF;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      last_rx   = 8'h00;
      prev_rxv  = 1'b0;
      cs_stable = 0;
      prev_cs   = bus.cs_n;
    end else begin
      if (bus.rx_valid) begin
        act_rxv++;
        chk("rx_valid_back_to_back", 32'(prev_rxv), 32'd0);
        chk("rx_pending", 32'(exp_rx.size() > 0), 32'd1);
        if (exp_rx.size() > 0) last_rx = exp_rx.pop_front();
        chk("rx_data", 32'(bus.rx_data), 32'(last_rx));
      end else begin
        chk("rx_hold", 32'(bus.rx_data), 32'(last_rx));
      end
      prev_rxv = bus.rx_valid;
      if (bus.frame_err) act_ferr++;
      if (bus.tx_underrun) act_und++;
      if (!bus.miso_oe) chk("miso_idle", 32'(bus.miso), 32'd0);
      if (bus.cs_n == prev_cs) cs_stable++;
      else cs_stable = 0;
      prev_cs = bus.cs_n;
      if (cs_stable >= 6) chk("miso_oe", 32'(bus.miso_oe), 32'(!bus.cs_n));
    end
  end

  task automatic write_tx(input logic [7:0] b);
    chk("tx_ready_before_write", 32'(bus.tx_ready), 32'(!model_full));
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    model_full   = 1'b1;
    model_buf    = b;
  endtask

  task automatic cs_fall();
    bus.cs_n = 1'b0;
    cur_tx   = model_load();
    repeat (12) @(negedge clk);
  endtask

  task automatic cs_rise(input int half, input bit aborted);
    repeat (half) @(negedge clk);
    bus.cs_n = 1'b1;
    if (aborted) exp_ferr++;
    repeat (12) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, input int half,
                      input bit wr, input logic [7:0] wb, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      repeat (half) @(negedge clk);
      bus.sclk = 1'b1;
      mi = {mi[6:0], bus.miso};
      if (i == 7) begin
        exp_rx.push_back(mo);
        n_rx++;
      end
      repeat (half) @(negedge clk);
      if (i == 7 && wr) write_tx(wb);
      bus.sclk = 1'b0;
    end
    if (nbits > 0) chk("miso_bits", 32'(mi), 32'(cur_tx >> (8 - nbits)));
    if (nbits == 8) cur_tx = model_load();
  endtask

  task automatic checkpoint();
    chk("rx_valid_count", 32'(act_rxv), 32'(n_rx));
    chk("frame_err_count", 32'(act_ferr), 32'(exp_ferr));
    chk("underrun_count", 32'(act_und), 32'(exp_und));
    chk("tx_ready", 32'(bus.tx_ready), 32'(!model_full));
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] b;
    int u0, r0, f0, half, nfr, nbits;
    bit abort, wr;

    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_pulses", 32'({bus.rx_valid, bus.frame_err, bus.tx_underrun, bus.miso}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: preloaded A5 out, 3C in
    write_tx(8'hA5);
    @(negedge clk);
    chk("t1_tx_ready_full", 32'(bus.tx_ready), 32'd0);
    cs_fall();
    chk("t1_tx_ready_after_load", 32'(bus.tx_ready), 32'd1);
    xfer(8'h3C, 8, 25, 1'b0, 8'h00, mi);
    chk("t1_miso", 32'(mi), 32'hA5);
    cs_rise(25, 1'b0);
    chk("t1_rx_data", 32'(bus.rx_data), 32'h3C);
    checkpoint();

    // 2: empty buffer shifts FF with an underrun
    u0 = act_und;
    cs_fall();
    chk("t2_underrun_pulse", 32'(act_und - u0), 32'd1);
    xfer(8'h00, 8, 10, 1'b0, 8'h00, mi);
    chk("t2_miso", 32'(mi), 32'hFF);
    cs_rise(10, 1'b0);
    chk("t2_rx_data", 32'(bus.rx_data), 32'h00);
    checkpoint();

    // 3: three back-to-back frames
    r0 = act_rxv;
    write_tx(8'hC1);
    cs_fall();
    xfer(8'h11, 8, 12, 1'b1, 8'hC2, mi);
    chk("t3_miso0", 32'(mi), 32'hC1);
    xfer(8'h22, 8, 12, 1'b0, 8'h00, mi);
    chk("t3_miso1", 32'(mi), 32'hC2);
    xfer(8'h33, 8, 12, 1'b0, 8'h00, mi);
    chk("t3_miso2", 32'(mi), 32'hFF);
    cs_rise(12, 1'b0);
    chk("t3_rx_count", 32'(act_rxv - r0), 32'd3);
    chk("t3_rx_data", 32'(bus.rx_data), 32'h33);
    checkpoint();

    // 4: abort after 5 bits, then a clean frame
    r0 = act_rxv; f0 = act_ferr;
    cs_fall();
    xfer(8'hE7, 5, 8, 1'b0, 8'h00, mi);
    cs_rise(8, 1'b1);
    chk("t4_frame_err", 32'(act_ferr - f0), 32'd1);
    chk("t4_no_rx", 32'(act_rxv - r0), 32'd0);
    chk("t4_rx_kept", 32'(bus.rx_data), 32'h33);
    cs_fall();
    xfer(8'h5A, 8, 8, 1'b0, 8'h00, mi);
    cs_rise(8, 1'b0);
    chk("t4_rx_data", 32'(bus.rx_data), 32'h5A);
    checkpoint();

    // 5: reset mid-frame
    f0 = act_ferr;
    cs_fall();
    xfer(8'h99, 4, 8, 1'b0, 8'h00, mi);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_miso_oe", 32'(bus.miso_oe), 32'd0);
    chk("t5_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("t5_rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("t5_rst_outs", 32'({bus.rx_valid, bus.frame_err, bus.tx_underrun, bus.miso}), 32'd0);
    bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    model_full = 1'b0;
    exp_rx.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    cs_fall();
    xfer(8'h81, 8, 9, 1'b0, 8'h00, mi);
    cs_rise(9, 1'b0);
    chk("t5_rx_data", 32'(bus.rx_data), 32'h81);
    chk("t5_no_frame_err", 32'(act_ferr - f0), 32'd0);
    checkpoint();

    // 6: sclk activity while deselected, tx_valid held
    r0 = act_rxv;
    chk("t6_tx_ready_before", 32'(bus.tx_ready), 32'(!model_full));
    bus.tx_data = 8'h6E; bus.tx_valid = 1'b1;
    model_full = 1'b1; model_buf = 8'h6E;
    for (int i = 0; i < 16; i++) begin
      bus.mosi = i[0];
      repeat (6) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (6) @(negedge clk);
      bus.sclk = 1'b0;
    end
    bus.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_rx", 32'(act_rxv - r0), 32'd0);
    chk("t6_miso_oe", 32'(bus.miso_oe), 32'd0);
    chk("t6_tx_ready", 32'(bus.tx_ready), 32'd0);
    cs_fall();
    xfer(8'h42, 8, 8, 1'b0, 8'h00, mi);
    chk("t6_miso_loaded_once", 32'(mi), 32'h6E);
    cs_rise(8, 1'b0);
    checkpoint();

    // randomized sessions
    for (int s = 0; s < 30; s++) begin
      half = $urandom_range(6, 20);
      if (!model_full && ($urandom % 2 == 0)) write_tx(8'($urandom));
      cs_fall();
      nfr = $urandom_range(1, 3);
      abort = 1'b0;
      for (int f = 0; f < nfr; f++) begin
        nbits = 8;
        if ((f == nfr - 1) && ($urandom % 5 == 0)) nbits = $urandom_range(0, 7);
        abort = (nbits > 0) && (nbits < 8);
        wr = !model_full && (nbits == 8) && ($urandom % 2 == 0);
        b = 8'($urandom);
        xfer(8'($urandom), nbits, half, wr, b, mi);
      end
      cs_rise(half, abort);
      checkpoint();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
